fp_mant_divider: RTL and testbench

- Sequential restoring shift-subtract divider for floating-point mantissas. It is the inverse counterpart of the shift-add mantissa multiplier in the FP ALU.
- Computes quotient = floor((dividend << FRAC) / divisor) and remainder, producing one quotient bit per cycle.
- Sits beside the multiplier in the FP datapath and feeds the FP divide normaliser/rounder. The remainder supplies the sticky information.

---
 rtl/fp_mant_divider_if.sv | 25 ++
 rtl/fp_mant_divider.sv | 118 +++++++++++
 tb/tb_fp_mant_divider.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fp_mant_divider_if.sv
// Handshake and result bus between the FP datapath and the mantissa divider.
// The master drives the request; the slave (the divider) returns status and results.
interface fp_mant_divider_if #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned FRAC  = 28
);
    logic                    start;
    logic [WIDTH-1:0]        dividend;
    logic [WIDTH-1:0]        divisor;
    logic                    busy;
    logic                    done;
    logic [WIDTH+FRAC-1:0]   quotient;
    logic [WIDTH-1:0]        remainder;
    logic                    div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/fp_mant_divider.sv
// Restoring shift-subtract mantissa divider: quotient = floor((dividend << FRAC) / divisor),
// one quotient bit per cycle; the remainder feeds the sticky bit of the divide rounder.
// Optional build macro FP_DIV_EARLY_EXIT_EN: finish as soon as the partial remainder and
// all unconsumed numerator bits are zero (same results, shorter latency).
module fp_mant_divider #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned FRAC  = 28
) (
    input  logic              clk,
    input  logic              reset,
    fp_mant_divider_if.slave  bus
);
    localparam int unsigned N  = WIDTH + FRAC;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } stateType;

    stateType          state;
    logic [N-1:0]      numReg;
    logic [N-1:0]      numNext;
    logic [N-1:0]      quoNext;
    logic [WIDTH-1:0]  divisorReg;
    logic [WIDTH-1:0]  partial;
    logic [WIDTH-1:0]  partialNext;
    logic [WIDTH:0]    trial;
    logic              fits;
    logic [CW-1:0]     count;
    logic [CW-1:0]     countNext;
`ifdef FP_DIV_EARLY_EXIT_EN
    logic              earlyExit;
`endif

    // One restoring step: bring down the next numerator bit, subtract if it fits.
    always_comb begin
        trial       = {partial, numReg[N-1]};
        fits        = (trial >= {1'b0, divisorReg});
        partialNext = fits ? WIDTH'(trial - {1'b0, divisorReg}) : trial[WIDTH-1:0];
        quoNext     = {bus.quotient[N-2:0], fits};
        numNext     = {numReg[N-2:0], 1'b0};
        countNext   = count - CW'(1);
`ifdef FP_DIV_EARLY_EXIT_EN
        // Nothing left to divide: every remaining quotient bit is zero.
        earlyExit   = (partialNext == '0) && (numNext == '0);
`endif
    end

    // Control FSM and datapath registers; all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            numReg          <= '0;
            divisorReg      <= '0;
            partial         <= '0;
            count           <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor != '0) begin
                            divisorReg      <= bus.divisor;
                            numReg          <= {bus.dividend, {FRAC{1'b0}}};
                            partial         <= '0;
                            count           <= CW'(N);
                            bus.div_by_zero <= 1'b0;
                            bus.busy        <= 1'b1;
                            state           <= RUN;
                        end else begin
                            // Divide by zero: saturate quotient, pass dividend through.
                            bus.quotient    <= '1;
                            bus.remainder   <= bus.dividend;
                            bus.div_by_zero <= 1'b1;
                            bus.done        <= 1'b1;
                            state           <= DONE;
                        end
                    end
                end
                RUN: begin
                    numReg       <= numNext;
                    partial      <= partialNext;
                    count        <= countNext;
                    bus.quotient <= quoNext;
                    if (countNext == '0) begin
                        bus.remainder <= partialNext;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        state         <= DONE;
                    end
`ifdef FP_DIV_EARLY_EXIT_EN
                    else if (earlyExit) begin
                        // Align the quotient as if the remaining zero bits had been shifted in.
                        bus.quotient  <= quoNext << countNext;
                        bus.remainder <= partialNext;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        state         <= DONE;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mant_divider.sv
// Directed testbench for fp_mant_divider with hand-computed expected results.
module tb_fp_mant_divider;
    localparam int unsigned WIDTH = 28;
    localparam int unsigned FRAC  = 28;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fp_mant_divider_if #(.WIDTH(WIDTH), .FRAC(FRAC)) bus ();

    fp_mant_divider #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Issue one start (cycle 0) and follow it to done; optionally poke a second start at irqCyc.
    task automatic runOp(input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs,
                         input int irqCyc, input logic [WIDTH-1:0] irqDvd,
                         input logic [WIDTH-1:0] irqDvs,
                         output int doneCyc, output int busyCnt);
        int cyc;
        cyc     = 0;
        doneCyc = -1;
        busyCnt = 0;
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        while (doneCyc < 0 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            bus.start = (cyc == irqCyc);
            if (cyc == irqCyc) begin
                bus.dividend = irqDvd;
                bus.divisor  = irqDvs;
            end
            @(negedge clk);
            if (bus.busy) busyCnt++;
            if (bus.done) doneCyc = cyc;
        end
        if (doneCyc < 0) checkVal("done_timeout", 64'(cyc), 64'(0));
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        checkVal("done_one_cycle", 64'(bus.done), 64'(0));
        checkVal("busy_after_done", 64'(bus.busy), 64'(0));
    endtask

    initial begin
        int doneCyc;
        int busyCnt;
        int doneSeen;

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkVal("rst_busy", 64'(bus.busy), 64'(0));
        checkVal("rst_done", 64'(bus.done), 64'(0));
        checkVal("rst_quot", 64'(bus.quotient), 64'(0));
        checkVal("rst_rem", 64'(bus.remainder), 64'(0));
        checkVal("rst_dbz", 64'(bus.div_by_zero), 64'(0));

        // Exact division 12/3.
        runOp(28'd12, 28'd3, -1, '0, '0, doneCyc, busyCnt);
`ifdef FP_DIV_EARLY_EXIT_EN
        checkVal("exact_early_done", 64'(doneCyc >= 2 && doneCyc <= 31), 64'(1));
`else
        checkVal("exact_done_cyc", 64'(doneCyc), 64'(57));
`endif
        checkVal("exact_busy_cnt", 64'(busyCnt), 64'(doneCyc - 1));
        checkVal("exact_quot", 64'(bus.quotient), 64'h40000000);
        checkVal("exact_rem", 64'(bus.remainder), 64'(0));
        checkVal("exact_dbz", 64'(bus.div_by_zero), 64'(0));

        // Repeating fraction 1/3.
        runOp(28'd1, 28'd3, -1, '0, '0, doneCyc, busyCnt);
        checkVal("third_done_cyc", 64'(doneCyc), 64'(57));
        checkVal("third_quot", 64'(bus.quotient), 64'h5555555);
        checkVal("third_rem", 64'(bus.remainder), 64'(1));

        // Normalised mantissas 1.0 / 1.5.
        runOp(28'h8000000, 28'hC000000, -1, '0, '0, doneCyc, busyCnt);
        checkVal("norm_quot", 64'(bus.quotient), 64'hAAAAAAA);
        checkVal("norm_rem", 64'(bus.remainder), 64'h8000000);

        // Divide by zero.
        runOp(28'h123, 28'h0, -1, '0, '0, doneCyc, busyCnt);
        checkVal("dbz_done_cyc", 64'(doneCyc), 64'(1));
        checkVal("dbz_busy_cnt", 64'(busyCnt), 64'(0));
        checkVal("dbz_flag", 64'(bus.div_by_zero), 64'(1));
        checkVal("dbz_quot", 64'(bus.quotient), 64'hFFFFFFFFFFFFFF);
        checkVal("dbz_rem", 64'(bus.remainder), 64'h123);
        repeat (3) @(negedge clk);
        checkVal("dbz_hold_flag", 64'(bus.div_by_zero), 64'(1));
        checkVal("dbz_hold_rem", 64'(bus.remainder), 64'h123);
        runOp(28'd12, 28'd3, -1, '0, '0, doneCyc, busyCnt);
        checkVal("dbz_cleared", 64'(bus.div_by_zero), 64'(0));
        checkVal("dbz_next_quot", 64'(bus.quotient), 64'h40000000);

        // Reset in the middle of a run.
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.dividend = 28'hFFFFFFF;
        bus.divisor  = 28'd1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (c == 20) begin
                @(negedge clk);
                checkVal("midrst_busy_before", 64'(bus.busy), 64'(1));
                reset = 1'b1;
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkVal("midrst_busy", 64'(bus.busy), 64'(0));
        checkVal("midrst_done", 64'(bus.done), 64'(0));
        checkVal("midrst_quot", 64'(bus.quotient), 64'(0));
        doneSeen = 0;
        repeat (70) begin
            @(negedge clk);
            if (bus.done) doneSeen++;
        end
        checkVal("midrst_no_done", 64'(doneSeen), 64'(0));
        runOp(28'hFFFFFFF, 28'd1, -1, '0, '0, doneCyc, busyCnt);
        checkVal("rerun_quot", 64'(bus.quotient), 64'hFFFFFFF0000000);
        checkVal("rerun_rem", 64'(bus.remainder), 64'(0));

        // Start while busy is ignored; first result arrives on schedule.
        runOp(28'd1, 28'd3, 10, 28'd12, 28'd3, doneCyc, busyCnt);
        checkVal("ignore_done_cyc", 64'(doneCyc), 64'(57));
        checkVal("ignore_quot", 64'(bus.quotient), 64'h5555555);
        checkVal("ignore_rem", 64'(bus.remainder), 64'(1));
        runOp(28'd12, 28'd3, -1, '0, '0, doneCyc, busyCnt);
        checkVal("reissue_quot", 64'(bus.quotient), 64'h40000000);
        checkVal("reissue_rem", 64'(bus.remainder), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
